// File: rtl/lcd_pkg.sv
// lcd_pkg: state encoding, timing constants and per-state length lookup for the LCD read sequencer.
package lcd_pkg;
  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_SETUP_H  = 4'd1;
  localparam logic [3:0] S_EN_H     = 4'd2;
  localparam logic [3:0] S_HOLD_H   = 4'd3;
  localparam logic [3:0] S_INTER    = 4'd4;
  localparam logic [3:0] S_SETUP_L  = 4'd5;
  localparam logic [3:0] S_EN_L     = 4'd6;
  localparam logic [3:0] S_HOLD_L   = 4'd7;
  localparam logic [3:0] S_POLL_GAP = 4'd8;
  localparam logic [3:0] S_DONE     = 4'd9;
  localparam int T_SETUP   = 3;
  localparam int T_EN_READ = 20;
  localparam int T_HOLD    = 3;
  localparam int T_INTER   = 50;
  localparam int POLL_MAX  = 4095;
  // Terminal count (length - 1) for each timed state; untimed states use 0.
  function automatic logic [15:0] stateLast(input logic [3:0] s);
    return (s == S_SETUP_H || s == S_SETUP_L) ? 16'(T_SETUP - 1) :
           (s == S_EN_H || s == S_EN_L)       ? 16'(T_EN_READ - 1) :
           (s == S_HOLD_H || s == S_HOLD_L)   ? 16'(T_HOLD - 1) :
           (s == S_INTER || s == S_POLL_GAP)  ? 16'(T_INTER - 1) : 16'd0;
  endfunction
endpackage

// File: rtl/lcd_timer.sv
// lcd_timer: 16-bit cycle counter with synchronous clear and terminal-count compare.
module lcd_timer (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        iClear,
  input  logic [15:0] iLast,
  output logic        oDone
);
  logic [15:0] count;
  always_ff @(posedge Clock)
    count <= (Reset || iClear) ? 16'd0 : count + 16'd1;
  assign oDone = count == iLast;
endmodule

// File: rtl/lcd_nibble_reader.sv
// lcd_nibble_reader: 4-bit HD44780-style read sequencer assembling one byte from two EN strobes,
// optionally polling the busy flag until DB7 clears or the poll limit is reached.
module lcd_nibble_reader
  import lcd_pkg::*;
#(
  parameter int POLL_LIMIT = POLL_MAX
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iReadBegin,
  input  logic       iRS,
  input  logic       iPoll,
  input  logic [3:0] iLCD_Data,
  output logic       oLCD_EN,
  output logic       oLCD_RW,
  output logic       oLCD_RS,
  output logic [7:0] oData,
  output logic       oReadDone,
  output logic       oTimeout,
  output logic       oActive
);
  logic [3:0] state, nextState;
  logic [3:0] hiNib, loNib;
  logic [11:0] pollCount;
  logic rsLatch, pollLatch, tDone, busyRead, pollAgain;

  lcd_timer uTimer (
    .Clock (Clock),
    .Reset (Reset),
    .iClear(nextState != state || state == S_IDLE),
    .iLast (stateLast(state)),
    .oDone (tDone)
  );

  assign busyRead  = pollLatch && !rsLatch && hiNib[3];
  assign pollAgain = busyRead && pollCount < 12'(POLL_LIMIT);

  always_comb begin
    nextState = S_IDLE;
    case (state)
      S_IDLE:     nextState = iReadBegin ? S_SETUP_H : S_IDLE;
      S_SETUP_H:  nextState = tDone ? S_EN_H : S_SETUP_H;
      S_EN_H:     nextState = tDone ? S_HOLD_H : S_EN_H;
      S_HOLD_H:   nextState = tDone ? S_INTER : S_HOLD_H;
      S_INTER:    nextState = tDone ? S_SETUP_L : S_INTER;
      S_SETUP_L:  nextState = tDone ? S_EN_L : S_SETUP_L;
      S_EN_L:     nextState = tDone ? S_HOLD_L : S_EN_L;
      S_HOLD_L:   nextState = tDone ? (pollAgain ? S_POLL_GAP : S_DONE) : S_HOLD_L;
      S_POLL_GAP: nextState = tDone ? S_SETUP_H : S_POLL_GAP;
      default:    nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= S_IDLE;
      rsLatch   <= 1'b0;
      pollLatch <= 1'b0;
      hiNib     <= 4'h0;
      loNib     <= 4'h0;
      pollCount <= 12'd0;
      oData     <= 8'h00;
      oTimeout  <= 1'b0;
    end else begin
      state <= nextState;
      if (state == S_IDLE && iReadBegin) begin
        rsLatch   <= iRS;
        pollLatch <= iPoll;
        pollCount <= 12'd0;
      end
      if (state == S_EN_H && tDone) hiNib <= iLCD_Data;
      if (state == S_EN_L && tDone) loNib <= iLCD_Data;
      if (state == S_POLL_GAP && tDone) pollCount <= pollCount + 12'd1;
      // Result registers load on entry to DONE so they are valid alongside oReadDone.
      if (state == S_HOLD_L && nextState == S_DONE) begin
        oData    <= {hiNib, loNib};
        oTimeout <= busyRead;
      end
    end
  end

  assign oActive   = state != S_IDLE && state <= S_DONE;
  assign oLCD_EN   = state == S_EN_H || state == S_EN_L;
  assign oLCD_RW   = oActive && state != S_DONE;
  assign oLCD_RS   = oActive && rsLatch;
  assign oReadDone = state == S_DONE;
endmodule

// File: doc/lcd_nibble_reader.md
LCD_NIBBLE_READER -- requirements
Module: lcd_nibble_reader

Interface
REQ-001 Clock  input  1  system clock, 50 MHz (20 ns period); all timing below is in Clock cycles.
REQ-002 Reset  input  1  reset Reset, synchronous, active-high; clock Clock.
REQ-003 iReadBegin  input  1  request one read transaction; sampled only in IDLE.
REQ-004 iRS  input  1  register select; 0 = busy flag/address read, 1 = data RAM read; latched at start.
REQ-005 iPoll  input  1  1 = repeat busy reads until DB7 = 0; latched at start; ignored when iRS = 1.
REQ-006 iLCD_Data  input  4  LCD DB7..DB4 read-back nibble.
REQ-007 oLCD_EN  output  1  LCD enable strobe.
REQ-008 oLCD_RW  output  1  LCD R/W; 1 = read; top level tristates the DB drivers while this is 1.
REQ-009 oLCD_RS  output  1  latched iRS, driven for the whole transaction.
REQ-010 oData  output  8  assembled byte {high nibble, low nibble}; held until the next completion or Reset.
REQ-011 oReadDone  output  1  one-cycle pulse; oData is valid in that cycle.
REQ-012 oTimeout  output  1  valid with oReadDone; 1 = poll limit hit with busy still set.
REQ-013 oActive  output  1  1 in every state except IDLE.

Function
REQ-014 States: IDLE, SETUP_H, EN_H, HOLD_H, INTER, SETUP_L, EN_L, HOLD_L, POLL_GAP, DONE.
REQ-015 On each state entry a 16-bit cycle counter is cleared; a timed state of length N exits on the cycle its count equals N-1.
REQ-016 IDLE: outputs EN = 0, RW = 0, RS = 0, oActive = 0; on iReadBegin = 1, latch iRS/iPoll and go to SETUP_H.
REQ-017 SETUP_H: RW = 1, EN = 0, 3 cycles (60 ns address setup), then go to EN_H.
REQ-018 EN_H: EN = 1, 20 cycles (400 ns, covers 360 ns data delay); capture iLCD_Data into the high nibble on the last cycle; then go to HOLD_H.
REQ-019 HOLD_H: EN = 0, RW = 1, 3 cycles, then go to INTER.
REQ-020 INTER: EN = 0, RW = 1, 50 cycles (1 us), then go to SETUP_L.
REQ-021 SETUP_L, EN_L and HOLD_L mirror REQ-017 to REQ-019 with capture into the low nibble.
REQ-022 After HOLD_L: if the poll is latched, RS = 0, high nibble bit3 = 1 and the poll count is below 4095, go to POLL_GAP; otherwise go to DONE.
REQ-023 POLL_GAP: RW = 1, EN = 0, 50 cycles; increment the 12-bit poll count; then go to SETUP_H.
REQ-024 DONE: 1 cycle; load oData; pulse oReadDone; set oTimeout if the poll limit was reached with DB7 = 1; return to IDLE.
REQ-025 Non-poll latency: the first SETUP_H cycle is cycle 1, and DONE (oReadDone) falls in cycle 103.
REQ-026 iReadBegin outside IDLE is ignored; iRS/iPoll changes mid-transaction have no effect.
REQ-027 Invalid state encoding: go to IDLE next cycle with IDLE outputs.
REQ-028 oData, oTimeout and oLCD_RS change only in DONE, IDLE (RS only) or Reset.

Reset
REQ-029 Reset in any cycle: next state IDLE; EN = 0, RW = 0, RS = 0, oReadDone = 0, oTimeout = 0, oActive = 0, oData = 8'h00; counters cleared.
REQ-030 Reset mid-transaction discards the partial nibbles and produces no oReadDone pulse.

Structure
REQ-031 Shared package lcd_pkg holds the state encoding (4-bit) and timing constants T_SETUP = 3, T_EN_READ = 20, T_HOLD = 3, T_INTER = 50, POLL_MAX = 4095.
REQ-032 Sub-module lcd_timer: 16-bit cycle counter with a synchronous clear and a terminal-count compare against an N-1 input.
REQ-033 Outputs are decoded from registered state and the latched nibbles; no combinational path from iLCD_Data to outputs.

Verification
REQ-034 iRS = 1, iPoll = 0, model drives 4'hA then 4'h5 -> oData = 8'hA5, oReadDone in cycle 103, oTimeout = 0.
REQ-035 Measure EN high width = 20 cycles, RW setup before EN rise = 3 cycles, EN fall to nibble change = 3 cycles, and EN low gap = 56 cycles.
REQ-036 iRS = 0, iPoll = 1, busy reads 8'h80, 8'h80, then 8'h03 -> exactly 3 transactions, oData = 8'h03, oTimeout = 0.
REQ-037 iPoll = 1 with busy stuck (8'hFF) -> 4096 reads, then oReadDone with oTimeout = 1 and oData = 8'hFF.
REQ-038 Reset asserted in EN_L -> next cycle EN = 0, RW = 0, oData = 0, no oReadDone; a later read returns correct data.
REQ-039 iReadBegin pulsed during INTER -> ignored; a single oReadDone; iReadBegin held high -> back-to-back transactions separated by one IDLE cycle.
